// File: rtl/noc_vc_fifo.sv
// Multi-channel virtual-channel FIFO for the NoC router input stage.
// Shared load/consume ports, per-channel queues, registered flags.
module noc_vc_fifo #(
    parameter int BIT_WIDTH = 16,
    parameter int ADDR_LEN  = 3,
    parameter int N_CH      = 2,
    parameter int AF_LEVEL  = 6,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CH_W-1:0]      load_ch,
    input  logic [BIT_WIDTH-1:0] data_in,
    input  logic                 consume,
    input  logic [CH_W-1:0]      consume_ch,
    output logic [BIT_WIDTH:0]   data_out,
    output logic [N_CH-1:0]      empty,
    output logic [N_CH-1:0]      full,
    output logic [N_CH-1:0]      almost_full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 1 << ADDR_LEN;
    localparam int NSEL  = 1 << CH_W;

    typedef logic [ADDR_LEN-1:0] ptr_t;
    typedef logic [ADDR_LEN:0]   cnt_t;

    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_ZERO = cnt_t'(0);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t CNT_AF   = cnt_t'(AF_LEVEL);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_RDY,
        ST_FULL
    } ch_state_e;

    logic [BIT_WIDTH-1:0] mem [N_CH][DEPTH];

    ptr_t      wr_ptr    [N_CH];
    ptr_t      rd_ptr    [N_CH];
    cnt_t      count     [N_CH];
    cnt_t      count_nxt [N_CH];
    ch_state_e state     [N_CH];
    ch_state_e state_nxt [N_CH];

    logic [NSEL-1:0]      ch_ok;
    logic                 ld_hit;
    logic                 cs_hit;
    logic [N_CH-1:0]      ld_sel;
    logic [N_CH-1:0]      cs_sel;
    logic [N_CH-1:0]      wr_en;
    logic [N_CH-1:0]      rd_en;
    logic [N_CH-1:0]      af_q;
    logic [BIT_WIDTH-1:0] rd_word;
    logic [BIT_WIDTH-1:0] flit_q;
    logic                 valid_q;
    logic                 ovf_q;
    logic                 unf_q;

    // Indices beyond N_CH select nothing, so such requests are silently ignored.
    always_comb begin
        ch_ok = '0;
        for (int i = 0; i < NSEL; i++) begin
            ch_ok[i] = (i < N_CH);
        end
    end

    assign ld_hit = load && ch_ok[load_ch];
    assign cs_hit = consume && ch_ok[consume_ch];

    // A full channel still accepts a write when the same edge frees a slot.
    always_comb begin
        ld_sel = '0;
        cs_sel = '0;
        rd_en  = '0;
        wr_en  = '0;
        for (int c = 0; c < N_CH; c++) begin
            ld_sel[c] = ld_hit && (load_ch == CH_W'(c));
            cs_sel[c] = cs_hit && (consume_ch == CH_W'(c));
            rd_en[c]  = cs_sel[c] && (state[c] != ST_EMPTY);
            wr_en[c]  = ld_sel[c] && ((state[c] != ST_FULL) || rd_en[c]);
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            count_nxt[c] = count[c];
            state_nxt[c] = ST_RDY;
            unique case ({wr_en[c], rd_en[c]})
                2'b10:   count_nxt[c] = count[c] + CNT_ONE;
                2'b01:   count_nxt[c] = count[c] - CNT_ONE;
                default: count_nxt[c] = count[c];
            endcase
            unique case (1'b1)
                (count_nxt[c] == CNT_ZERO): state_nxt[c] = ST_EMPTY;
                (count_nxt[c] == CNT_FULL): state_nxt[c] = ST_FULL;
                default:                    state_nxt[c] = ST_RDY;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_en[c]) begin
                rd_word = mem[c][rd_ptr[c]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
                state[c]  <= ST_EMPTY;
            end
            af_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (wr_en[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
                end
                if (rd_en[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
                end
                count[c] <= count_nxt[c];
                state[c] <= state_nxt[c];
                af_q[c]  <= (count_nxt[c] >= CNT_AF);
            end
        end
    end

    // Storage is not reset; a full-channel write lands on the slot being read,
    // which still yields the old flit because the read samples before update.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (wr_en[c]) begin
                mem[c][wr_ptr[c]] <= data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            flit_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            valid_q <= |rd_en;
            if (|rd_en) begin
                flit_q <= rd_word;
            end
            ovf_q <= |(ld_sel & ~wr_en);
            unf_q <= |(cs_sel & ~rd_en);
        end
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            empty[c] = (state[c] == ST_EMPTY);
            full[c]  = (state[c] == ST_FULL);
        end
    end

    assign almost_full = af_q;
    assign data_out    = {valid_q, flit_q};
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_noc_vc_fifo.sv
// Scoreboard bench for noc_vc_fifo: stimulus queues expected reads,
// a negedge monitor pops and compares each valid output flit.
module tb_noc_vc_fifo;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [0:0]  load_ch;
    logic [15:0] data_in;
    logic        consume;
    logic [0:0]  consume_ch;
    logic [16:0] data_out;
    logic [1:0]  empty;
    logic [1:0]  full;
    logic [1:0]  almost_full;
    logic        overflow;
    logic        underflow;

    int tests = 0;
    int fails = 0;

    logic [16:0] exp_q[$];
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    noc_vc_fifo #(
        .BIT_WIDTH(16),
        .ADDR_LEN (3),
        .N_CH     (2),
        .AF_LEVEL (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_ch    (load_ch),
        .data_in    (data_in),
        .consume    (consume),
        .consume_ch (consume_ch),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int msize(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    // Reference queue behaviour: read decided on pre-cycle occupancy,
    // a write to a full channel only proceeds if the same channel is read.
    task automatic step(input logic ld, input logic [0:0] lch,
                        input logic [15:0] din, input logic cs,
                        input logic [0:0] cch);
        bit rd;
        bit wr;
        logic [15:0] v;
        rd = cs && (msize(int'(cch)) > 0);
        wr = ld && ((msize(int'(lch)) < 8) || (rd && (cch == lch)));
        if (rd) begin
            v = (cch == 1'b0) ? q0.pop_front() : q1.pop_front();
            exp_q.push_back({1'b1, v});
        end
        if (wr) begin
            if (lch == 1'b0) q0.push_back(din);
            else             q1.push_back(din);
        end
        load       = ld;
        load_ch    = lch;
        data_in    = din;
        consume    = cs;
        consume_ch = cch;
        @(posedge clk);
        #1;
        load    = 1'b0;
        consume = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && data_out[16]) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected: got %h expected none", data_out);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    fails++;
                    $display("FAIL rd_data: got %h expected %h", data_out, e);
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        load_ch    = 1'b0;
        data_in    = '0;
        consume    = 1'b0;
        consume_ch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 32'h3);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_af", 32'(almost_full), 32'h0);
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_flags", 32'({overflow, underflow}), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // fill ch0 with 1..8
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
            chk($sformatf("fill_af_%0d", i), 32'(almost_full[0]),
                32'(i >= 6));
            chk($sformatf("fill_full_%0d", i), 32'(full[0]), 32'(i == 8));
        end
        chk("fill_ch1_empty", 32'(empty[1]), 32'h1);
        step(1'b1, 1'b0, 16'h0009, 1'b0, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'h1);
        chk("ovf_full", 32'(full[0]), 32'h1);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("ovf_clear", 32'(overflow), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        end
        chk("drain_empty0", 32'(empty[0]), 32'h1);
        chk("drain_af0", 32'(almost_full[0]), 32'h0);

        // pointer wrap on ch1
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'h0110 + 16'(i), 1'b0, 1'b0);
        chk("wrap_full1", 32'(full[1]), 32'h1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("wrap_empty1", 32'(empty[1]), 32'h1);

        // full channel, same-channel load + consume
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'h0200 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b0);
        chk("fullrw_full", 32'(full[0]), 32'h1);
        chk("fullrw_ovf", 32'(overflow), 32'h0);
        chk("fullrw_dout", 32'(data_out), 32'h10201);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("fullrw_empty", 32'(empty[0]), 32'h1);

        // empty channel, same-channel load + consume
        step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
        chk("emptyrw_unf", 32'(underflow), 32'h1);
        chk("emptyrw_valid", 32'(data_out[16]), 32'h0);
        chk("emptyrw_empty", 32'(empty[1]), 32'h0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("emptyrw_unf_clr", 32'(underflow), 32'h0);
        chk("emptyrw_dout", 32'(data_out), 32'h11234);

        // interleave
        step(1'b1, 1'b0, 16'h0301, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0401, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) step(1'b1, 1'b0, 16'h0302 + 16'(k), 1'b1, 1'b1);
            else            step(1'b1, 1'b1, 16'h0402 + 16'(k), 1'b1, 1'b0);
            chk($sformatf("ilv_empty_%0d", k), 32'(empty),
                32'({q1.size() == 0, q0.size() == 0}));
        end
        while (q0.size() > 0) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        while (q1.size() > 0) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("ilv_empty_end", 32'(empty), 32'h3);

        // asynchronous reset mid-stream
        step(1'b1, 1'b0, 16'h0501, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0502, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0601, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("pre_rst_dout", 32'(data_out), 32'h00501);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_empty", 32'(empty), 32'h3);
        chk("arst_full", 32'(full), 32'h0);
        chk("arst_dout", 32'(data_out), 32'h0);
        q0.delete();
        q1.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("arst_unf", 32'(underflow), 32'h1);
        chk("arst_valid", 32'(data_out[16]), 32'h0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
